music_key_debouncer: RTL and testbench

// Front-end conditioning stage for the six music-box key switches; feeds MusicKeysController.

---
 rtl/music_key_debouncer_pkg.sv | 15 +
 rtl/music_key_debouncer_if.sv | 30 +++
 rtl/music_key_debouncer_channel.sv | 127 ++++++++++++
 rtl/music_key_debouncer.sv | 60 ++++++
 tb/tb_music_key_debouncer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/music_key_debouncer_pkg.sv
// Shared definitions for the music-box user-interface front end.
package music_box_ui_pkg;

    localparam int NUM_MUSIC_KEYS          = 6;
    localparam int CLOCK_HZ                = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz

    typedef enum logic [1:0] {
        KEY_RELEASED        = 2'd0,
        KEY_CONFIRM_PRESS   = 2'd1,
        KEY_PRESSED         = 2'd2,
        KEY_CONFIRM_RELEASE = 2'd3
    } key_db_state_t;

endpackage : music_box_ui_pkg

// File: rtl/music_key_debouncer_if.sv
// Key bus between the raw switch pins, the debouncer and the recorder logic.
interface music_key_debouncer_if
    import music_box_ui_pkg::*;
#(
    parameter int NUM_KEYS = NUM_MUSIC_KEYS
);
    logic [NUM_KEYS-1:0] input_RawKey_n;
    logic [NUM_KEYS-1:0] output_Key_n;
    logic [NUM_KEYS-1:0] output_KeyPress;
    logic [NUM_KEYS-1:0] output_KeyRelease;
    logic [31:0]         debugString;

    // Master side drives the raw pins and consumes the conditioned keys.
    modport master (
        output input_RawKey_n,
        input  output_Key_n,
        input  output_KeyPress,
        input  output_KeyRelease,
        input  debugString
    );

    // Slave side is the debouncer itself.
    modport slave (
        input  input_RawKey_n,
        output output_Key_n,
        output output_KeyPress,
        output output_KeyRelease,
        output debugString
    );
endinterface : music_key_debouncer_if

// File: rtl/music_key_debouncer_channel.sv
// One key channel: 2-FF synchroniser, four-state debounce FSM, stability counter
// and registered level/pulse outputs.
module key_debounce_channel
    import music_box_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_n_i,
    output logic key_n_o,
    output logic press_o,
    output logic release_o,
    output logic press_next_o
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    key_db_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             key_n_q, key_n_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // State, counter, synchroniser and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= KEY_RELEASED;
            cnt_q     <= CNT_ZERO;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            key_n_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= raw_n_i;
            sync2_q   <= sync1_q;
            key_n_q   <= key_n_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next-state and stability-counter logic; a level change must persist DEBOUNCE_CYCLES samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = CNT_ZERO;
        case (state_q)
            KEY_RELEASED: begin
                if (!sync2_q) begin
                    state_d = KEY_CONFIRM_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = KEY_RELEASED;
                end
            end
            KEY_CONFIRM_PRESS: begin
                if (sync2_q) begin
                    state_d = KEY_RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = KEY_PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            KEY_PRESSED: begin
                if (sync2_q) begin
                    state_d = KEY_CONFIRM_RELEASE;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = KEY_PRESSED;
                end
            end
            KEY_CONFIRM_RELEASE: begin
                if (!sync2_q) begin
                    state_d = KEY_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = KEY_RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = KEY_RELEASED;
            end
        endcase
    end

    // Output decode: level changes and one-cycle pulses coincide with accepting a change.
    always_comb begin
        key_n_d   = key_n_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            KEY_CONFIRM_PRESS: begin
                if (!sync2_q && (cnt_q == CNT_LAST)) begin
                    key_n_d = 1'b0;
                    press_d = 1'b1;
                end else begin
                    key_n_d = key_n_q;
                end
            end
            KEY_CONFIRM_RELEASE: begin
                if (sync2_q && (cnt_q == CNT_LAST)) begin
                    key_n_d   = 1'b1;
                    release_d = 1'b1;
                end else begin
                    key_n_d = key_n_q;
                end
            end
            default: begin
                key_n_d = key_n_q;
            end
        endcase
    end

    assign key_n_o      = key_n_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign press_next_o = press_d;

endmodule : key_debounce_channel

// File: rtl/music_key_debouncer.sv
// Six-key debouncer top: per-key channels, press-event counter and debug word packing.
module music_key_debouncer
    import music_box_ui_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_MUSIC_KEYS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset,
    music_key_debouncer_if.slave  key_bus
);
    logic [NUM_KEYS-1:0] key_n_s;
    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] release_s;
    logic [NUM_KEYS-1:0] press_next_s;
    logic [15:0]         press_inc_s;
    logic [15:0]         press_count_q, press_count_d;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i        (clock_50Mhz),
            .rst_i        (reset),
            .raw_n_i      (key_bus.input_RawKey_n[g]),
            .key_n_o      (key_n_s[g]),
            .press_o      (press_s[g]),
            .release_o    (release_s[g]),
            .press_next_o (press_next_s[g])
        );
    end

    // Count presses being accepted on this edge so the count moves with output_Key_n.
    always_comb begin
        press_inc_s = 16'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (press_next_s[i]) begin
                press_inc_s = press_inc_s + 16'd1;
            end else begin
                press_inc_s = press_inc_s;
            end
        end
        press_count_d = press_count_q + press_inc_s;
    end

    // Press-event counter register, wraps naturally at 16 bits.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            press_count_q <= 16'd0;
        end else begin
            press_count_q <= press_count_d;
        end
    end

    assign key_bus.output_Key_n      = key_n_s;
    assign key_bus.output_KeyPress   = press_s;
    assign key_bus.output_KeyRelease = release_s;
    assign key_bus.debugString       = {press_count_q, {(16 - NUM_KEYS){1'b0}}, key_n_s};

endmodule : music_key_debouncer

// File: tb/tb_music_key_debouncer.sv
// Self-checking bench: directed scenarios plus randomized bouncy key activity,
// compared every cycle against a run-length reference model.
module tb_music_key_debouncer;
    localparam int NK = 6;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] raw_r = '1;
    bit            chk_en = 1'b0;
    int            total = 0;
    int            bad = 0;

    // Reference model: a change is accepted once the synchronised level has
    // differed from the debounced level for DB consecutive samples.
    bit [NK-1:0] m_s1, m_s2, m_out, m_press, m_rel;
    int          m_run [NK];
    bit [15:0]   m_pc;

    music_key_debouncer_if #(.NUM_KEYS(NK)) bus ();

    music_key_debouncer #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock_50Mhz (clk),
        .reset       (rst),
        .key_bus     (bus.slave)
    );

    assign bus.input_RawKey_n = raw_r;

    always #10 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model update on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '1; m_s2 = '1; m_out = '1; m_press = '0; m_rel = '0; m_pc = 16'd0;
            for (int i = 0; i < NK; i++) m_run[i] = 0;
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < NK; i++) begin
                if (m_s2[i] != m_out[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_out[i] = m_s2[i];
                        if (m_s2[i] == 1'b0) begin
                            m_press[i] = 1'b1;
                            m_pc = m_pc + 16'd1;
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw_r;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_value("key_n",   32'(bus.output_Key_n),      32'(m_out));
            check_value("press",   32'(bus.output_KeyPress),   32'(m_press));
            check_value("release", 32'(bus.output_KeyRelease), 32'(m_rel));
            check_value("debug",   bus.debugString,            {m_pc, 10'd0, m_out});
        end
    end

    initial begin
        // 1: reset with all raw keys low
        rst   = 1'b1;
        raw_r = 6'b000000;
        wait_edges(3);
        chk_en = 1'b1;
        check_value("rst_key_n", 32'(bus.output_Key_n), 32'h3F);
        check_value("rst_press", 32'(bus.output_KeyPress | bus.output_KeyRelease), 32'h0);
        check_value("rst_debug", bus.debugString, 32'h0000_003F);
        raw_r = 6'b111111;
        wait_edges(2);
        rst = 1'b0;
        wait_edges(3);

        // 2: clean press on key 0
        raw_r[0] = 1'b0;
        wait_edges(9);
        check_value("t2_early", 32'(bus.output_Key_n[0]), 32'd1);
        wait_edges(1);
        check_value("t2_key",   32'(bus.output_Key_n[0]), 32'd0);
        check_value("t2_pulse", 32'(bus.output_KeyPress[0]), 32'd1);
        check_value("t2_count", 32'(bus.debugString[31:16]), 32'd1);
        wait_edges(1);
        check_value("t2_pulse_end", 32'(bus.output_KeyPress[0]), 32'd0);

        // 3: bounce rejection on key 2
        raw_r[2] = 1'b0; wait_edges(5);
        raw_r[2] = 1'b1; wait_edges(1);
        raw_r[2] = 1'b0; wait_edges(5);
        raw_r[2] = 1'b1; wait_edges(12);
        check_value("t3_key", 32'(bus.output_Key_n[2]), 32'd1);

        // 4: release of key 0
        raw_r[0] = 1'b1;
        wait_edges(10);
        check_value("t4_key",   32'(bus.output_Key_n[0]), 32'd1);
        check_value("t4_pulse", 32'(bus.output_KeyRelease[0]), 32'd1);
        check_value("t4_count", 32'(bus.debugString[31:16]), 32'd1);

        // 5: simultaneous press on keys 5..3
        raw_r[5:3] = 3'b000;
        wait_edges(9);
        check_value("t5_early", 32'(bus.output_Key_n[5:3]), 32'h7);
        wait_edges(1);
        check_value("t5_key",   32'(bus.output_Key_n[5:3]), 32'h0);
        check_value("t5_pulse", 32'(bus.output_KeyPress[5:3]), 32'h7);
        check_value("t5_count", 32'(bus.debugString[31:16]), 32'd4);

        // 6: reset in the middle of debouncing key 1
        raw_r[1] = 1'b0;
        wait_edges(4);
        rst = 1'b1;
        wait_edges(1);
        check_value("t6_in_rst", 32'(bus.output_Key_n[1]), 32'd1);
        rst = 1'b0;
        wait_edges(9);
        check_value("t6_early", 32'(bus.output_Key_n[1]), 32'd1);
        wait_edges(1);
        check_value("t6_key", 32'(bus.output_Key_n[1]), 32'd0);

        // Randomized bouncy activity with occasional resets
        raw_r = 6'b111111;
        wait_edges(20);
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(11) == 0) raw_r[k] = ~raw_r[k];
            end
            rst = ($urandom_range(799) == 0);
            wait_edges(1);
        end
        rst = 1'b0;
        wait_edges(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule : tb_music_key_debouncer
